event_latch_arbiter: RTL and testbench
======================================

# event_latch_arbiter

Sequencer for a bank of set/clear event latches, such as bus-error, interrupt-level-change or transfer-done flags raised by the 68k bus engine. It captures single-cycle SET pulses from N sources into sticky pending latches. It offers them one at a time, round-robin, to a single consumer (the Pi-side status/IRQ path) over a valid/ack handshake, and it clears each latch only when the consumer acknowledges it. It sits between the bus-side event producers and the register interface that the Pi polls.

## Interface
- N_SRC, 4, number of event sources (2..16)
- CLK  in  1  system clock; all logic on rising edge
- clocked_reset  in  1  reset, asynchronous, active-high
- SET  in  N_SRC  per-source event pulse, sampled on rising CLK
- MASK  in  N_SRC  1 = source may latch but is never offered
- FLUSH  in  1  synchronous clear of all pending latches and abort of any offer
- REQ_VALID  out  1  an event is being offered
- REQ_ID  out  $clog2(N_SRC)  index of the offered source
- REQ_ACK  in  1  consumer accepts the offered event
- PENDING  out  N_SRC  raw latch state (registered)
- OVF  out  N_SRC  sticky "event lost" flags (see Configuration)
- OVF_CLR  in  1  synchronous clear of OVF

## Operation
- Latch i: set when SET[i]=1; cleared by ACK of i or by FLUSH. If SET[i] arrives in the same cycle as its ACK, SET wins and the latch stays 1, so the event is offered again later.
- FSM states: IDLE, OFFER, RETIRE.
  - IDLE: if (PENDING & ~MASK) != 0, select the first set bit searching upward from rr_ptr with wrap-around. Register it into REQ_ID and go to OFFER. Otherwise stay in IDLE.
  - OFFER: REQ_VALID=1. REQ_ID is held stable and the offer is never retracted by a MASK change. On REQ_ACK: clear PENDING[REQ_ID] (subject to the SET-wins rule), set rr_ptr to REQ_ID+1 mod N_SRC, and go to RETIRE.
  - RETIRE: REQ_VALID=0 for exactly one cycle, then go to IDLE.
- REQ_ACK outside OFFER is ignored.
- FLUSH in any state:
  - PENDING is cleared to 0 (SET in the same cycle is ignored).
  - The FSM goes to IDLE.
  - REQ_ACK in the same cycle is ignored.
  - rr_ptr is unchanged.
- rr_ptr is $clog2(N_SRC) bits. For non-power-of-two N_SRC, the wrap is an explicit compare, so rr_ptr is never ≥ N_SRC.

## Timing
- Reset values:
  - REQ_VALID=0, REQ_ID=0, PENDING=0, OVF=0
  - FSM=IDLE, rr_ptr=0
  - Outputs drop asynchronously on reset assertion.
- Latency: SET[i] sampled at edge t → PENDING[i]=1 after t → REQ_VALID=1 after t+1, assuming IDLE and no higher-priority bit.
- ACK at edge a → REQ_VALID=0 after a; the earliest next offer is REQ_VALID=1 after a+2. Minimum offer spacing is 3 cycles.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset release is synchronised externally; the block assumes deassertion is clean w.r.t. CLK.

## Configuration
- EVENT_LATCH_ARBITER_OVF_EN defined:
  - OVF[i] sets when SET[i]=1 while PENDING[i]=1 and the latch is not being cleared in that cycle.
  - OVF[i] clears on OVF_CLR.
  - If set and clear occur together, set wins.
- Undefined: OVF is tied to 0 and OVF_CLR is ignored; no overflow registers are synthesised.

## Structure
- Package event_latch_pkg:
  - FSM state enum (IDLE/OFFER/RETIRE)
  - N_SRC upper-bound constant
  - round-robin pick function (pending, mask, ptr → index, found)
- Sub-module event_latch_cell, one instance per source:
  - holds the pending bit and, when the macro is defined, the OVF bit
  - implements the SET-wins, FLUSH-wins priority locally
  - takes CLK and clocked_reset
- The top level holds the FSM, rr_ptr and REQ_ID registers.

## Test plan
- Reset mid-OFFER: assert clocked_reset asynchronously between edges → REQ_VALID, PENDING and OVF read 0 immediately. After release with SET=4'b0010 → REQ_ID=1, and REQ_VALID rises 2 cycles after SET.
- Round-robin: SET=4'b1111 in one cycle, ACK on every offer → grant order 0,1,2,3, offers spaced 3 cycles apart. Then SET=4'b0011 → order 0,1 (rr_ptr wrapped to 0).
- Fairness: with source 0 re-pulsed after every ACK and SET=4'b1001 initially → the order alternates 0,3,0,3, and source 3 is never starved.
- SET/ACK collision: offer ID 2, assert SET[2] in the same cycle as REQ_ACK → PENDING[2] stays 1, ID 2 is re-offered, and with the macro OVF[2]=0.
- Mask and flush:
  - MASK=4'b0001 with PENDING=4'b0001 → no offer while masked.
  - Unmask → offer ID 0.
  - FLUSH during that OFFER → REQ_VALID=0 and PENDING=0 next cycle; an ACK in the flush cycle has no effect.
- Overflow (macro defined): SET[1] twice before ACK → OVF[1]=1 after the second edge. OVF_CLR → 0. OVF_CLR together with a new overflow → stays 1. With the macro undefined → OVF is 0 throughout.

Source files
------------

// File: rtl/event_latch_pkg.sv
// Shared state encoding, size limits and the round-robin pick used by event_latch_arbiter.
package event_latch_pkg;

  localparam int N_SRC_MAX = 16;
  localparam int IDX_W_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    RETIRE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [IDX_W_MAX-1:0] idx;
  } pick_t;

  // First pending, unmasked source at or above ptr, wrapping at n_src rather than at a power of two.
  function automatic pick_t rr_pick(input logic [N_SRC_MAX-1:0] pending,
                                    input logic [N_SRC_MAX-1:0] mask,
                                    input logic [IDX_W_MAX-1:0] ptr,
                                    input int                   n_src);
    pick_t r;
    int    k;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < N_SRC_MAX; i++) begin
      if (i < n_src) begin
        k = int'(ptr) + i;
        if (k >= n_src) k = k - n_src;
        if (!r.found && pending[k[IDX_W_MAX-1:0]] && !mask[k[IDX_W_MAX-1:0]]) begin
          r.found = 1'b1;
          r.idx   = k[IDX_W_MAX-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/event_latch_cell.sv
// One sticky event latch: FLUSH beats SET, SET beats ACK-clear.
// Overflow flag present only when EVENT_LATCH_ARBITER_OVF_EN is defined.
module event_latch_cell (
  input  logic CLK,
  input  logic clocked_reset,
  input  logic i_set,
  input  logic i_clr,
  input  logic i_flush,
  input  logic i_ovf_clr,
  output logic o_pending,
  output logic o_ovf
);

  logic r_pending;

  // NOTE: non-blocking so every latch and the FSM update from the same pre-edge values.
  always_ff @(posedge CLK or posedge clocked_reset) begin
    if (clocked_reset)  r_pending <= 1'b0;
    else if (i_flush)   r_pending <= 1'b0;
    else if (i_set)     r_pending <= 1'b1;
    else if (i_clr)     r_pending <= 1'b0;
  end

  assign o_pending = r_pending;

`ifdef EVENT_LATCH_ARBITER_OVF_EN
  logic r_ovf;
  logic w_ovf_set;

  // A SET colliding with its own ACK re-arms the latch instead of losing the event.
  assign w_ovf_set = i_set & r_pending & ~i_clr & ~i_flush;

  always_ff @(posedge CLK or posedge clocked_reset) begin
    if (clocked_reset)   r_ovf <= 1'b0;
    else if (w_ovf_set)  r_ovf <= 1'b1;
    else if (i_ovf_clr)  r_ovf <= 1'b0;
  end

  assign o_ovf = r_ovf;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = i_ovf_clr;
  assign o_ovf            = 1'b0;
`endif

endmodule

// File: rtl/event_latch_arbiter.sv
// Sticky event latches offered one at a time, round-robin, over a valid/ack handshake.
// Define EVENT_LATCH_ARBITER_OVF_EN to build the per-source "event lost" flags.
module event_latch_arbiter
  import event_latch_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic                     CLK,
  input  logic                     clocked_reset,
  input  logic [N_SRC-1:0]         SET,
  input  logic [N_SRC-1:0]         MASK,
  input  logic                     FLUSH,
  output logic                     REQ_VALID,
  output logic [$clog2(N_SRC)-1:0] REQ_ID,
  input  logic                     REQ_ACK,
  output logic [N_SRC-1:0]         PENDING,
  output logic [N_SRC-1:0]         OVF,
  input  logic                     OVF_CLR
);

  localparam int ID_W = $clog2(N_SRC);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [ID_W-1:0] r_req_id;
  logic [ID_W-1:0] w_req_id_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_rr_ptr_nxt;
  logic            r_req_valid;
  logic            w_ack_fire;
  pick_t           w_pick;
  logic            w_unused_pick_idx;

  assign w_ack_fire        = (r_state == OFFER) & REQ_ACK & ~FLUSH;
  assign w_pick            = rr_pick(N_SRC_MAX'(PENDING), N_SRC_MAX'(MASK),
                                     IDX_W_MAX'(r_rr_ptr), N_SRC);
  assign w_unused_pick_idx = ^w_pick.idx;

  // NOTE: every signal gets its default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_id_nxt = r_req_id;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          w_state_nxt  = OFFER;
          w_req_id_nxt = w_pick.idx[ID_W-1:0];
        end
      end
      OFFER: begin
        if (w_ack_fire) begin
          w_state_nxt  = RETIRE;
          w_rr_ptr_nxt = (r_req_id == ID_W'(N_SRC - 1)) ? '0 : r_req_id + 1'b1;
        end
      end
      RETIRE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Flush aborts any offer but leaves the fairness pointer where it was.
    if (FLUSH) begin
      w_state_nxt  = IDLE;
      w_req_id_nxt = r_req_id;
    end
  end

  always_ff @(posedge CLK or posedge clocked_reset) begin
    if (clocked_reset) begin
      r_state     <= IDLE;
      r_req_id    <= '0;
      r_rr_ptr    <= '0;
      r_req_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_id    <= w_req_id_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_req_valid <= (w_state_nxt == OFFER);
    end
  end

  assign REQ_VALID = r_req_valid;
  assign REQ_ID    = r_req_id;

  for (genvar g = 0; g < N_SRC; g++) begin : g_cell
    event_latch_cell u_cell (
      .CLK          (CLK),
      .clocked_reset(clocked_reset),
      .i_set        (SET[g]),
      .i_clr        (w_ack_fire && (r_req_id == ID_W'(g))),
      .i_flush      (FLUSH),
      .i_ovf_clr    (OVF_CLR),
      .o_pending    (PENDING[g]),
      .o_ovf        (OVF[g])
    );
  end

endmodule

// File: tb/tb_event_latch_arbiter.sv
// Scoreboarded bench for event_latch_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_event_latch_arbiter;

  localparam int N = 4;

`ifdef EVENT_LATCH_ARBITER_OVF_EN
  localparam logic [N-1:0] OVF_B1 = 4'b0010;
`else
  localparam logic [N-1:0] OVF_B1 = 4'b0000;
`endif

  logic         CLK = 1'b0;
  logic         clocked_reset = 1'b0;
  logic [N-1:0] SET = '0;
  logic [N-1:0] MASK = '0;
  logic         FLUSH = 1'b0;
  logic         REQ_ACK = 1'b0;
  logic         OVF_CLR = 1'b0;
  logic         REQ_VALID;
  logic [1:0]   REQ_ID;
  logic [N-1:0] PENDING;
  logic [N-1:0] OVF;

  event_latch_arbiter #(.N_SRC(N)) dut (
    .CLK          (CLK),
    .clocked_reset(clocked_reset),
    .SET          (SET),
    .MASK         (MASK),
    .FLUSH        (FLUSH),
    .REQ_VALID    (REQ_VALID),
    .REQ_ID       (REQ_ID),
    .REQ_ACK      (REQ_ACK),
    .PENDING      (PENDING),
    .OVF          (OVF),
    .OVF_CLR      (OVF_CLR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int id;
    int cyc;
  } grant_t;

  grant_t glog[$];
  int     exp_q[$];

  // Behavioural reference: one offer at a time, a one-cycle gap after each accepted ACK.
  bit           m_valid;
  bit           m_retire;
  int           m_id;
  int           m_rr;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_ovf;
  logic [N-1:0] m_old;
  bit           m_ack_ok;
  bit           m_clr;
  int           m_k;
  bit           prev_v;
  int           e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc++;

  always @(posedge CLK or posedge clocked_reset) begin
    if (clocked_reset) begin
      m_valid = 0; m_retire = 0; m_id = 0; m_rr = 0;
      m_pend = '0; m_ovf = '0;
      exp_q.delete();
    end else begin
      m_old    = m_pend;
      m_ack_ok = m_valid && REQ_ACK && !FLUSH;
      for (int i = 0; i < N; i++) begin
        m_clr = m_ack_ok && (m_id == i);
`ifdef EVENT_LATCH_ARBITER_OVF_EN
        if (SET[i] && m_old[i] && !FLUSH && !m_clr) m_ovf[i] = 1'b1;
        else if (OVF_CLR)                           m_ovf[i] = 1'b0;
`endif
        if (FLUSH)       m_pend[i] = 1'b0;
        else if (SET[i]) m_pend[i] = 1'b1;
        else if (m_clr)  m_pend[i] = 1'b0;
      end
      if (FLUSH) begin
        m_valid = 0; m_retire = 0;
      end else if (m_valid) begin
        if (m_ack_ok) begin
          m_valid = 0; m_retire = 1; m_rr = (m_id + 1) % N;
        end
      end else if (m_retire) begin
        m_retire = 0;
      end else begin
        for (int j = 0; j < N; j++) begin
          m_k = (m_rr + j) % N;
          if (!m_valid && m_old[m_k] && !MASK[m_k]) begin
            m_valid = 1; m_id = m_k; exp_q.push_back(m_k);
          end
        end
      end
    end
  end

  // Monitor: compares every cycle and pops the scoreboard on each new offer.
  always @(negedge CLK) begin
    if (clocked_reset) begin
      prev_v = 1'b0;
    end else begin
      check("req_valid", REQ_VALID, m_valid);
      check("pending", PENDING, m_pend);
      check("ovf", OVF, m_ovf);
      if (REQ_VALID && !prev_v) begin
        check("scoreboard nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("offer id", REQ_ID, e);
        end
        glog.push_back('{id: int'(REQ_ID), cyc: cyc});
      end
      if (REQ_VALID && m_valid) check("req_id hold", REQ_ID, m_id);
      prev_v = REQ_VALID;
    end
  end

  task automatic tick(input logic [N-1:0] s = '0, input logic a = 1'b0,
                      input logic f = 1'b0, input logic oc = 1'b0);
    SET = s; REQ_ACK = a; FLUSH = f; OVF_CLR = oc;
    @(negedge CLK);
  endtask

  task automatic wait_offer(input string name);
    int n = 0;
    while (!REQ_VALID && n < 20) begin
      tick();
      n++;
    end
    check({name, " offer seen"}, REQ_VALID, 1'b1);
  endtask

  task automatic run_ack(input int n, input logic [N-1:0] s0, input bit repulse);
    logic [N-1:0] s;
    logic         a;
    logic [1:0]   id;
    s = s0;
    for (int c = 0; c < n; c++) begin
      a  = REQ_VALID;
      id = REQ_ID;
      tick(s, a);
      s = (repulse && a) ? (4'b0001 | (4'b0001 << id)) : 4'b0000;
    end
  endtask

  task automatic do_reset();
    #2 clocked_reset = 1'b1;
    @(negedge CLK);
    #2 clocked_reset = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_set;
    logic [N-1:0] rs;
    logic ra, rf, roc;

    #2 clocked_reset = 1'b1;
    #1;
    check("reset req_valid", REQ_VALID, 1'b0);
    check("reset req_id", REQ_ID, 2'd0);
    check("reset pending", PENDING, 4'b0000);
    check("reset ovf", OVF, 4'b0000);
    @(negedge CLK);
    #2 clocked_reset = 1'b0;
    @(negedge CLK);

    // Round-robin order and 3-cycle offer spacing.
    glog.delete();
    run_ack(16, 4'b1111, 1'b0);
    check("rr grant count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      check($sformatf("rr order %0d", i), glog[i].id, i);
      if (i > 0) check($sformatf("rr spacing %0d", i), glog[i].cyc - glog[i-1].cyc, 3);
    end
    glog.delete();
    run_ack(10, 4'b0011, 1'b0);
    check("rr wrap count", glog.size(), 2);
    for (int i = 0; i < 2 && i < glog.size(); i++)
      check($sformatf("rr wrap order %0d", i), glog[i].id, i);

    // Asynchronous reset in the middle of an offer.
    tick(4'b0100);
    tick();
    check("pre-reset offer", REQ_VALID, 1'b1);
    #2 clocked_reset = 1'b1;
    #1;
    check("async reset req_valid", REQ_VALID, 1'b0);
    check("async reset pending", PENDING, 4'b0000);
    check("async reset ovf", OVF, 4'b0000);
    @(negedge CLK);
    #2 clocked_reset = 1'b0;
    @(negedge CLK);
    glog.delete();
    tick(4'b0010);
    t_set = cyc;
    tick();
    tick();
    check("post-reset offers", glog.size(), 1);
    if (glog.size() > 0) begin
      check("post-reset id", glog[0].id, 1);
      check("post-reset latency", glog[0].cyc - t_set, 1);
    end
    tick('0, 1'b1);
    tick();

    // Fairness: both sources kept pending, grants must alternate.
    do_reset();
    glog.delete();
    run_ack(22, 4'b1001, 1'b1);
    check("fair grants >= 6", glog.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      check($sformatf("fair order %0d", i), glog[i].id, (i % 2 == 0) ? 0 : 3);
    run_ack(15, 4'b0000, 1'b0);

    // SET colliding with ACK of the same source.
    tick(4'b0100);
    wait_offer("coll");
    check("coll id", REQ_ID, 2'd2);
    tick(4'b0100, 1'b1);
    check("coll pending kept", PENDING[2], 1'b1);
    check("coll no ovf", OVF[2], 1'b0);
    wait_offer("coll re");
    check("coll reoffer id", REQ_ID, 2'd2);
    tick('0, 1'b1);
    tick();
    tick();

    // Mask holds off an offer; flush aborts one and swallows a same-cycle ACK.
    MASK = 4'b0001;
    tick(4'b0001);
    repeat (6) tick();
    check("masked no offer", REQ_VALID, 1'b0);
    check("masked pending", PENDING, 4'b0001);
    MASK = 4'b0000;
    wait_offer("unmask");
    check("unmask id", REQ_ID, 2'd0);
    tick('0, 1'b1, 1'b1);
    check("flush valid", REQ_VALID, 1'b0);
    check("flush pending", PENDING, 4'b0000);
    repeat (4) tick();
    check("no offer after flush", REQ_VALID, 1'b0);

    // Overflow set, clear, and set-beats-clear.
    tick(4'b0010);
    tick(4'b0010);
    check("ovf on second set", OVF, OVF_B1);
    tick('0, 1'b0, 1'b0, 1'b1);
    check("ovf cleared", OVF, 4'b0000);
    tick(4'b0010, 1'b0, 1'b0, 1'b1);
    check("ovf set beats clear", OVF, OVF_B1);
    wait_offer("ovf");
    tick('0, 1'b1);
    tick();
    tick('0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0) MASK = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      rs  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      ra  = REQ_VALID ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      rf  = ($urandom_range(0, 39) == 0);
      roc = ($urandom_range(0, 15) == 0);
      tick(rs, ra, rf, roc);
    end
    MASK = 4'b0000;
    run_ack(25, 4'b0000, 1'b0);
    check("all drained", PENDING, 4'b0000);
    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
